// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int KEY_TOG = 10;
  localparam int KEY_PRS = 9;
  localparam int KEY_EXT = 8;

  // Keyboard-to-host replies (ack, BAT, echo, resend, errors), not key codes.
  function automatic logic is_reply(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for one raw PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic line,
  output logic level
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], line};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 frame receiver and make/break decoder producing the 11-bit ps2_key event word.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 12000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        byte_stb,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_lvl, data_lvl, clk_q, fall;
  ps2_state_t    state, state_nx;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          ext, brk;
  logic          shift_en, par_en, frame_done, start_err, tmo_hit;
  logic          frame_good, frame_bad, is_prefix, emit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .line    (ps2_clk),
    .level   (clk_lvl)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .line    (ps2_data),
    .level   (data_lvl)
  );

  assign fall = clk_q & ~clk_lvl;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    frame_done = 1'b0;
    start_err  = 1'b0;
    // An edge in the same cycle as expiry keeps the frame alive.
    tmo_hit    = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC));
    case (state)
      IDLE: if (fall) begin
        if (!data_lvl) state_nx = DATA;
        else           start_err = 1'b1;
      end
      DATA: if (fall) begin
        shift_en = 1'b1;
        if (bit_cnt == 3'd7) state_nx = PARITY;
      end
      PARITY: if (fall) begin
        par_en   = 1'b1;
        state_nx = STOP;
      end
      STOP: if (fall) begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (tmo_hit) state_nx = IDLE;
  end

  assign frame_good = frame_done && (^{shreg, par_bit}) && data_lvl;
  assign frame_bad  = start_err || tmo_hit || (frame_done && !frame_good);
  assign is_prefix  = (shreg == PS2_EXT) || (shreg == PS2_BRK) || (shreg == PS2_PAUSE);
  assign emit       = frame_good && !is_prefix && !(is_reply(shreg) && !ext && !brk);

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_q     <= 1'b1;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      ps2_key   <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_q     <= clk_lvl;
      byte_stb  <= frame_good;
      frame_err <= frame_bad;

      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)       shreg   <= {data_lvl, shreg[7:1]};
      if (par_en)         par_bit <= data_lvl;

      if (state == IDLE || fall)             tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT_CYC))  tmo_cnt <= tmo_cnt + 1'b1;

      if (frame_bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (frame_good) begin
        if (shreg == PS2_EXT) ext <= 1'b1;
        if (shreg == PS2_BRK) brk <= 1'b1;
        if (emit) begin
          ps2_key[KEY_TOG] <= ~ps2_key[KEY_TOG];
          ps2_key[KEY_PRS] <= ~brk;
          ps2_key[KEY_EXT] <= ext;
          ps2_key[7:0]     <= shreg;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule
